// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS pipeline front end: reset and exception
// addresses, next-PC selector operation codes, the instruction-fetch state
// encoding and the layout of one buffered fetch entry.
package mips_pkg;

  // Address loaded into the PC by reset and the exception entry point.
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

  // Next-PC selector operations (used by the selector, shared here).
  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_EXC = 2'b11;

  // Fetch controller states: BOOT is the single idle cycle after reset,
  // FETCH issues requests, HOLD parks a fetched word while ID is stalled.
  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } fetch_state_t;

  // One fetched instruction together with the PC + 4 it came from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus;
  } hold_entry_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf
// One-entry register that parks a fetched instruction and its PC + 4 while
// the ID stage is stalled.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, empties the entry to zero
//   load  - capture din at the next edge
//   clear - discard the entry (wins over load)
//   din   - {instr, pcplus} to capture
//   dout  - currently held {instr, pcplus}
module fetch_hold_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  hold_entry_t din,
  output hold_entry_t dout
);

  // Entry register: a discard must beat a capture so a flush never lets a
  // same-cycle fetched word survive.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch
// Instruction-fetch front end: owns the PC, issues fetch requests to
// instruction memory, writes the IF/ID register, absorbs ID stalls with a
// one-entry hold buffer, and handles flushes and misaligned fetch targets.
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   npc_addr             - next address chosen by the next-PC selector
//   pcplus               - PC + 4 presented to the next-PC selector
//   imem_req, imem_addr  - fetch request valid and address (= PC)
//   imem_ready           - memory accepts, imem_rdata valid same cycle
//   imem_rdata           - fetched instruction word
//   stallD, flushD       - ID stall and exception flush
//   instrD, pcplusD      - IF/ID instruction and its PC + 4
//   validD               - IF/ID holds a real instruction
//   adel_f, badvaddr_f   - misaligned fetch target trap pulse and address
module pc_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] EXC_VEC  = mips_pkg::EXC_VEC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc_addr,
  output logic [31:0] pcplus,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stallD,
  input  logic        flushD,
  output logic [31:0] instrD,
  output logic [31:0] pcplusD,
  output logic        validD,
  output logic        adel_f,
  output logic [31:0] badvaddr_f
);

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  hold_entry_t  buf_q;
  hold_entry_t  adv_entry;
  logic         advance;
  logic         bubble;
  logic         buf_load;
  logic         buf_clear;
  logic         redirect;
  logic         misaligned;

  // The PC drives both the fetch address and the sequential successor.
  assign pcplus    = pc + 32'd4;
  assign imem_addr = pc;
  assign imem_req  = (state == FETCH);

  // The PC only moves when an instruction enters IF/ID or on a flush; at
  // that moment a non-word-aligned target is trapped instead of fetched.
  assign redirect   = advance || flushD;
  assign misaligned = redirect && (npc_addr[1:0] != 2'b00);

  fetch_hold_buf u_hold_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_load),
    .clear (buf_clear),
    .din   ({imem_rdata, pcplus}),
    .dout  (buf_q)
  );

  // State register for the fetch controller.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control. A ready fetch either advances straight
  // into IF/ID or, when ID is stalled, is parked in the hold buffer. A flush
  // overrides everything: nothing advances and the buffer is discarded.
  always_comb begin
    state_next = state;
    advance    = 1'b0;
    bubble     = 1'b0;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    adv_entry  = '0;
    unique case (state)
      BOOT: begin
        state_next = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          if (!stallD) begin
            advance   = 1'b1;
            adv_entry = {imem_rdata, pcplus};
          end else begin
            buf_load   = 1'b1;
            state_next = HOLD;
          end
        end else if (!stallD) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        if (!stallD) begin
          advance    = 1'b1;
          adv_entry  = buf_q;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
    if (flushD) begin
      state_next = FETCH;
      advance    = 1'b0;
      bubble     = 1'b0;
      buf_load   = 1'b0;
      buf_clear  = 1'b1;
    end
  end

  // PC, IF/ID register and trap reporting. The trap pulse lasts one cycle;
  // the captured bad address stays until the next trap or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      instrD     <= '0;
      pcplusD    <= '0;
      validD     <= 1'b0;
      adel_f     <= 1'b0;
      badvaddr_f <= '0;
    end else begin
      adel_f <= 1'b0;
      if (misaligned) begin
        pc         <= EXC_VEC;
        adel_f     <= 1'b1;
        badvaddr_f <= npc_addr;
      end else if (redirect) begin
        pc <= npc_addr;
      end
      if (flushD) begin
        validD <= 1'b0;
      end else if (advance) begin
        instrD  <= adv_entry.instr;
        pcplusD <= adv_entry.pcplus;
        validD  <= 1'b1;
      end else if (bubble) begin
        validD <= 1'b0;
      end
    end
  end

endmodule
